// File: rtl/game_turn_fsm_if.sv
// Command/status bundle between the turn controller and the game datapath.
// The controller uses the master side; sources and datapath use the slave side.
interface game_turn_fsm_if;
  logic       start_i;
  logic       btn_sel_i;
  logic       tick_1hz_i;
  logic       hi_is_down_i;
  logic       cards_match_i;
  logic       match_happened_i;
  logic       pause_done_i;
  logic       auto_pick1_valid_i;
  logic       auto_pick2_valid_i;
  logic [3:0] p1_score_i;
  logic [3:0] p2_score_i;
  logic       select_first_card_o;
  logic       select_second_card_o;
  logic       auto_select_first_o;
  logic       auto_select_second_o;
  logic       start_pause_o;
  logic       end_turn_o;
  logic       extra_turn_o;
  logic [3:0] turn_secs_o;
  logic       timeout_o;
  logic       game_over_o;
  logic [1:0] winner_o;

  modport master (
    input  start_i, btn_sel_i, tick_1hz_i, hi_is_down_i,
    input  cards_match_i, match_happened_i, pause_done_i,
    input  auto_pick1_valid_i, auto_pick2_valid_i,
    input  p1_score_i, p2_score_i,
    output select_first_card_o, select_second_card_o,
    output auto_select_first_o, auto_select_second_o,
    output start_pause_o, end_turn_o, extra_turn_o,
    output turn_secs_o, timeout_o, game_over_o, winner_o
  );

  modport slave (
    output start_i, btn_sel_i, tick_1hz_i, hi_is_down_i,
    output cards_match_i, match_happened_i, pause_done_i,
    output auto_pick1_valid_i, auto_pick2_valid_i,
    output p1_score_i, p2_score_i,
    input  select_first_card_o, select_second_card_o,
    input  auto_select_first_o, auto_select_second_o,
    input  start_pause_o, end_turn_o, extra_turn_o,
    input  turn_secs_o, timeout_o, game_over_o, winner_o
  );
endinterface

// File: rtl/game_turn_fsm.sv
// Memory-game turn controller: card selection, turn timer,
// reveal pause, turn hand-off and game-over detection.
module game_turn_fsm #(
  parameter int N_CARDS             = 16,
  parameter int TURN_SECS           = 15,
  parameter int EXTRA_TURN_ON_MATCH = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  game_turn_fsm_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, FIRST, SECOND, AUTO2, PAUSE, ENDT, CHK, OVER
  } state_t;

  localparam logic [3:0] RELOAD = 4'(TURN_SECS);
  localparam logic [4:0] PAIRS  = 5'(N_CARDS / 2);

  state_t     state, state_nx;
  logic [3:0] secs, secs_nx;
  logic       sel_ok, is_match, run, expire;
  logic       pause_nx, extra_nx, end_nx;
  logic       pause_q, extra_q, end_q, to_q;
  logic [4:0] score_sum;

  assign sel_ok    = bus.btn_sel_i & bus.hi_is_down_i;
  assign is_match  = bus.cards_match_i & bus.match_happened_i;
  assign run       = (state == FIRST) || (state == SECOND) || (state == AUTO2);
  // A valid manual select in the expiry cycle suppresses the timeout
  assign expire    = run && bus.tick_1hz_i && (secs == 4'd1) && !sel_ok;
  assign score_sum = {1'b0, bus.p1_score_i} + {1'b0, bus.p2_score_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      secs    <= RELOAD;
      pause_q <= 1'b0;
      extra_q <= 1'b0;
      end_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      secs    <= secs_nx;
      pause_q <= pause_nx;
      extra_q <= extra_nx;
      end_q   <= end_nx;
      to_q    <= expire;
    end
  end

  always_comb begin
    state_nx = state;
    secs_nx  = secs;
    pause_nx = 1'b0;
    extra_nx = 1'b0;
    if (run && bus.tick_1hz_i && secs != 4'd0 &&
        !(sel_ok && secs == 4'd1))
      secs_nx = secs - 4'd1;
    unique case (state)
      IDLE: if (bus.start_i) begin
        state_nx = FIRST;
        secs_nx  = RELOAD;
      end
      FIRST: begin
        if (sel_ok)
          state_nx = SECOND;
        else if (expire)
          state_nx = bus.auto_pick1_valid_i ? AUTO2 : CHK;
      end
      SECOND: begin
        if (sel_ok || (expire && bus.auto_pick2_valid_i)) begin
          if (is_match) begin
            state_nx = CHK;
            extra_nx = (EXTRA_TURN_ON_MATCH != 0);
          end else begin
            state_nx = PAUSE;
            pause_nx = 1'b1;
          end
        end else if (expire) begin
          state_nx = ENDT;
        end
      end
      AUTO2: begin
        if (!bus.auto_pick2_valid_i) begin
          state_nx = ENDT;
        end else if (is_match) begin
          state_nx = CHK;
          extra_nx = (EXTRA_TURN_ON_MATCH != 0);
        end else begin
          state_nx = PAUSE;
          pause_nx = 1'b1;
        end
      end
      PAUSE: if (bus.pause_done_i) state_nx = ENDT;
      ENDT: begin
        state_nx = FIRST;
        secs_nx  = RELOAD;
      end
      CHK: begin
        if (score_sum == PAIRS) begin
          state_nx = OVER;
        end else begin
          state_nx = FIRST;
          secs_nx  = RELOAD;
        end
      end
      OVER: state_nx = OVER;
    endcase
    end_nx = (state_nx == ENDT);
  end

  always_comb begin
    bus.select_first_card_o  = 1'b0;
    bus.select_second_card_o = 1'b0;
    bus.auto_select_first_o  = 1'b0;
    bus.auto_select_second_o = 1'b0;
    bus.game_over_o          = 1'b0;
    bus.winner_o             = 2'b00;
    unique case (state)
      FIRST: begin
        bus.select_first_card_o = sel_ok;
        bus.auto_select_first_o = expire & bus.auto_pick1_valid_i;
      end
      SECOND: begin
        bus.select_second_card_o = sel_ok;
        bus.auto_select_second_o = expire & bus.auto_pick2_valid_i;
      end
      AUTO2: bus.auto_select_second_o = bus.auto_pick2_valid_i;
      OVER: begin
        bus.game_over_o = 1'b1;
        if (bus.p1_score_i > bus.p2_score_i)
          bus.winner_o = 2'b01;
        else if (bus.p2_score_i > bus.p1_score_i)
          bus.winner_o = 2'b10;
        else
          bus.winner_o = 2'b11;
      end
      default: ;
    endcase
  end

  assign bus.start_pause_o = pause_q;
  assign bus.extra_turn_o  = extra_q;
  assign bus.end_turn_o    = end_q;
  assign bus.timeout_o     = to_q;
  assign bus.turn_secs_o   = secs;

endmodule

// File: tb/tb_game_turn_fsm.sv
// Directed table-driven bench for game_turn_fsm.
// Each row: one clock cycle of inputs and the outputs expected in it.
module tb_game_turn_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  game_turn_fsm_if bus ();

  game_turn_fsm #(
    .N_CARDS(16), .TURN_SECS(15), .EXTRA_TURN_ON_MATCH(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  localparam logic [8:0] ST = 9'h100, BT = 9'h080, HI = 9'h040;
  localparam logic [8:0] TK = 9'h020, CM = 9'h010, MH = 9'h008;
  localparam logic [8:0] PD = 9'h004, A1 = 9'h002, A2 = 9'h001;
  localparam logic [8:0] S1 = 9'h100, S2 = 9'h080, AS1 = 9'h040;
  localparam logic [8:0] AS2 = 9'h020, SP = 9'h010, ET = 9'h008;
  localparam logic [8:0] EX = 9'h004, TO = 9'h002, GO = 9'h001;

  typedef struct {
    string      name;
    logic [8:0] in;
    logic [3:0] p1;
    logic [3:0] p2;
    logic [8:0] e;
    logic [1:0] w;
    logic [3:0] s;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(string n, logic [8:0] in,
      logic [3:0] p1, logic [3:0] p2,
      logic [8:0] e, logic [1:0] w, logic [3:0] s);
    vec_t v;
    v.name = n; v.in = in; v.p1 = p1; v.p2 = p2;
    v.e = e; v.w = w; v.s = s;
    return v;
  endfunction

  task automatic drive(logic [8:0] in, logic [3:0] p1, logic [3:0] p2);
    {bus.start_i, bus.btn_sel_i, bus.hi_is_down_i, bus.tick_1hz_i,
     bus.cards_match_i, bus.match_happened_i, bus.pause_done_i,
     bus.auto_pick1_valid_i, bus.auto_pick2_valid_i} = in;
    bus.p1_score_i = p1;
    bus.p2_score_i = p2;
  endtask

  task automatic check(string n, logic [8:0] e, logic [1:0] w,
      logic [3:0] s);
    logic [14:0] got, exp;
    got = {bus.select_first_card_o, bus.select_second_card_o,
           bus.auto_select_first_o, bus.auto_select_second_o,
           bus.start_pause_o, bus.end_turn_o, bus.extra_turn_o,
           bus.timeout_o, bus.game_over_o, bus.winner_o,
           bus.turn_secs_o};
    exp = {e, w, s};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b_%b_%h required %b_%b_%h", n,
               got[14:6], got[5:4], got[3:0], e, w, s);
    end
  endtask

  task automatic cyc(vec_t v);
    @(posedge clk);
    #1;
    drive(v.in, v.p1, v.p2);
    #3;
    check(v.name, v.e, v.w, v.s);
  endtask

  task automatic do_reset(string n);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    drive('0, 4'd0, 4'd0);
    #1;
    check(n, '0, 2'b00, 4'd15);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    drive('0, 4'd0, 4'd0);
    tbl[0]  = mk("idle",         '0,             0, 0, '0, 0, 15);
    tbl[1]  = mk("start",        ST,             0, 0, '0, 0, 15);
    tbl[2]  = mk("sel1",         BT|HI,          0, 0, S1, 0, 15);
    tbl[3]  = mk("sel2_nomatch", BT|HI,          0, 0, S2, 0, 15);
    tbl[4]  = mk("start_pause",  '0,             0, 0, SP, 0, 15);
    tbl[5]  = mk("pause_hold",   ST|BT|HI|TK,    0, 0, '0, 0, 15);
    tbl[6]  = mk("pause_done",   PD,             0, 0, '0, 0, 15);
    tbl[7]  = mk("end_turn",     '0,             0, 0, ET, 0, 15);
    tbl[8]  = mk("sel_up_ign",   BT,             0, 0, '0, 0, 15);
    tbl[9]  = mk("sel1_again",   BT|HI,          0, 0, S1, 0, 15);
    tbl[10] = mk("sel2_match",   BT|HI|CM|MH,    1, 0, S2, 0, 15);
    tbl[11] = mk("extra_turn",   PD,             1, 0, EX, 0, 15);
    tbl[12] = mk("first_extra",  '0,             1, 0, '0, 0, 15);
    tbl[13] = mk("tick15",       TK,             1, 0, '0, 0, 15);
    tbl[14] = mk("sel1_14",      BT|HI,          1, 0, S1, 0, 14);
    tbl[15] = mk("sel2_cm_only", BT|HI|CM,       1, 0, S2, 0, 14);
    tbl[16] = mk("pause_14",     '0,             1, 0, SP, 0, 14);
    tbl[17] = mk("pd_14",        PD,             1, 0, '0, 0, 14);
    tbl[18] = mk("endt_14",      '0,             1, 0, ET, 0, 14);
    tbl[19] = mk("reload",       '0,             1, 0, '0, 0, 15);

    #12;
    check("reset", '0, 2'b00, 4'd15);
    #5;
    rst_n = 1'b1;

    foreach (tbl[i]) cyc(tbl[i]);

    // full countdown in FIRST then auto picks
    for (int i = 0; i < 14; i++)
      cyc(mk("first_tick", TK, 0, 0, '0, 0, 4'(15 - i)));
    cyc(mk("expire_auto1", TK|A1|A2, 0, 0, AS1, 0, 1));
    cyc(mk("auto2_timeout", TK|A2,   0, 0, AS2|TO, 0, 0));
    cyc(mk("auto_pause",    TK,      0, 0, SP, 0, 0));
    cyc(mk("auto_pd",       PD,      0, 0, '0, 0, 0));
    cyc(mk("auto_endt",     '0,      0, 0, ET, 0, 0));
    cyc(mk("auto_reload",   '0,      0, 0, '0, 0, 15));

    // select coinciding with the final tick in SECOND
    cyc(mk("c_sel1", BT|HI, 0, 0, S1, 0, 15));
    for (int i = 0; i < 14; i++)
      cyc(mk("second_tick", TK, 0, 0, '0, 0, 4'(15 - i)));
    cyc(mk("sel_beats_to", TK|BT|HI|A2, 0, 0, S2, 0, 1));
    cyc(mk("no_timeout",   '0,          0, 0, SP, 0, 1));
    cyc(mk("c_pd",         PD,          0, 0, '0, 0, 1));
    cyc(mk("c_endt",       '0,          0, 0, ET, 0, 1));
    cyc(mk("c_reload",     '0,          0, 0, '0, 0, 15));

    // last pair, P1 wins 5-3
    cyc(mk("d_sel1",  BT|HI,       5, 3, S1, 0, 15));
    cyc(mk("d_sel2",  BT|HI|CM|MH, 5, 3, S2, 0, 15));
    cyc(mk("d_chk",   '0,          5, 3, EX, 0, 15));
    cyc(mk("d_over",  '0,          5, 3, GO, 2'b01, 15));
    cyc(mk("d_quiet", ST|BT|HI|TK|A1|A2|PD, 5, 3, GO, 2'b01, 15));

    // tie 4-4, then winner follows scores
    do_reset("reset_tie");
    cyc(mk("e_start", ST,          4, 4, '0, 0, 15));
    cyc(mk("e_sel1",  BT|HI,       4, 4, S1, 0, 15));
    cyc(mk("e_sel2",  BT|HI|CM|MH, 4, 4, S2, 0, 15));
    cyc(mk("e_chk",   '0,          4, 4, EX, 0, 15));
    cyc(mk("e_tie",   '0,          4, 4, GO, 2'b11, 15));
    cyc(mk("e_p2win", '0,          3, 5, GO, 2'b10, 15));

    // asynchronous reset while in PAUSE
    do_reset("reset_f");
    cyc(mk("f_start", ST,    0, 0, '0, 0, 15));
    cyc(mk("f_sel1",  BT|HI, 0, 0, S1, 0, 15));
    cyc(mk("f_sel2",  BT|HI, 0, 0, S2, 0, 15));
    @(posedge clk);
    #1;
    drive('0, 4'd0, 4'd0);
    #1;
    check("f_in_pause", SP, 2'b00, 4'd15);
    rst_n = 1'b0;
    #1;
    check("f_async_rst", '0, 2'b00, 4'd15);
    #2;
    rst_n = 1'b1;
    cyc(mk("f_idle_sel", BT|HI, 0, 0, '0, 0, 15));
    cyc(mk("f_restart",  ST,    0, 0, '0, 0, 15));
    cyc(mk("f_sel1b",    BT|HI, 0, 0, S1, 0, 15));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
